// File: rtl/if_pkg.sv
`default_nettype none
// ============================================================================
// Package     : if_pkg
// Description : Shared types and constants for the instruction-fetch stage.
// Revision    : 1.0 - initial release
// ============================================================================
package if_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    VALID = 2'd2
  } if_state_e;

  // Instruction presented downstream out of reset (addi x0, x0, 0)
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  // Instruction addresses are word aligned
  localparam logic [31:0] ADDR_ALIGN_MASK = 32'hFFFF_FFFC;

  // Clear the byte-offset bits of a redirect target
  function automatic logic [31:0] align_addr(input logic [31:0] addr);
    return addr & ADDR_ALIGN_MASK;
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_pc_reg.sv
`default_nettype none
// ============================================================================
// Module      : if_pc_reg
// Description : Program counter register. Loads either the sequential
//               successor (pc + PC_INC) or an aligned redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_i,
  input  logic        sel_redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic [31:0] pc_o,
  output logic [31:0] pc_inc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  // Sequential successor wraps silently at the top of the address space
  assign pc_inc_o = pc_q + PC_INC;
  assign pc_o     = pc_q;

  // Select the next PC: hold, sequential step, or aligned redirect target
  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = sel_redirect_i ? align_addr(redirect_pc_i) : pc_inc_o;
    end
  end

  // PC register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_stage
// Description : Instruction-fetch stage. Single-outstanding req/gnt/rvalid
//               fetch, one-entry instruction buffer, IF/ID write strobe,
//               downstream stall and branch/jump redirect handling.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_INC   = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] next_pc,
  output logic [31:0] instr_out,
  output logic        ifid_write
);

  if_state_e   state_q, state_d;
  logic        squash_q, squash_d;
  logic        req_q;
  logic [31:0] instr_q, instr_d;
  logic [31:0] next_pc_q, next_pc_d;
  logic        pc_load;
  logic        pc_sel_redirect;
  logic [31:0] pc;
  logic [31:0] pc_inc;

  if_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_i         (pc_load),
    .sel_redirect_i (pc_sel_redirect),
    .redirect_pc_i  (redirect_pc),
    .pc_o           (pc),
    .pc_inc_o       (pc_inc)
  );

  // State, squash flag, registered request and instruction buffer.
  // The request register follows the next state so imem_req is a flop
  // output and stays low while reset is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      squash_q  <= 1'b0;
      req_q     <= 1'b0;
      instr_q   <= NOP_INSTR;
      next_pc_q <= '0;
    end else begin
      state_q   <= state_d;
      squash_q  <= squash_d;
      req_q     <= (state_d == FETCH);
      instr_q   <= instr_d;
      next_pc_q <= next_pc_d;
    end
  end

  // Next state: handshake progress, redirect squashing, buffer capture, PC updates
  always_comb begin
    state_d         = state_q;
    squash_d        = squash_q;
    instr_d         = instr_q;
    next_pc_d       = next_pc_q;
    pc_load         = 1'b0;
    pc_sel_redirect = 1'b0;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
        end
        // A grant coinciding with a redirect was for the old PC: squash its data
        if (req_q && imem_gnt) begin
          state_d  = WAIT;
          squash_d = redirect;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
          if (imem_rvalid) begin
            state_d  = FETCH;
            squash_d = 1'b0;
          end else begin
            squash_d = 1'b1;
          end
        end else if (imem_rvalid) begin
          if (squash_q) begin
            squash_d = 1'b0;
            state_d  = FETCH;
          end else begin
            instr_d   = imem_rdata;
            next_pc_d = pc_inc;
            state_d   = VALID;
          end
        end
      end
      VALID: begin
        if (redirect) begin
          pc_load         = 1'b1;
          pc_sel_redirect = 1'b1;
          state_d         = FETCH;
        end else if (!stall) begin
          pc_load = 1'b1;
          state_d = FETCH;
        end
      end
      default: begin
        state_d  = FETCH;
        squash_d = 1'b0;
      end
    endcase
  end

  // Outputs: IF/ID strobe is combinational, everything else comes from flops
  always_comb begin
    ifid_write = (state_q == VALID) && !stall && !redirect;
    imem_req   = req_q;
    imem_addr  = pc;
    instr_out  = instr_q;
    next_pc    = next_pc_q;
  end

endmodule
`default_nettype wire
